seed_load_ctrl: RTL

//  Upstream front-end for the 8-bit LFSR display stage.
//  - Synchronises the raw load push-button and the 8 seed slide switches.
//  - Debounces the button and emits exactly one single-cycle load pulse per accepted press.
//  - Presents a seed that is stable and registered alongside that pulse.

---
 rtl/seed_load_ctrl_pkg.sv | 14 +
 rtl/seed_load_ctrl_if.sv | 24 ++
 rtl/seed_load_ctrl_sync2.sv | 22 ++
 rtl/seed_load_ctrl.sv | 107 ++++++++++
 4 files changed

// File: rtl/seed_load_ctrl_pkg.sv
// Shared types for the LFSR front-end: debounce FSM state encoding and default seed width.
// Pure declarations; no latency, no flow control.
package lfsr_io_pkg;

  localparam int SEED_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

endpackage

// File: rtl/seed_load_ctrl_if.sv
// Button/switch inputs and load/seed outputs between the panel and the LFSR stage.
// Plain wires; no latency, no backpressure (load is a fire-and-forget pulse).
interface seed_load_ctrl_if
  import lfsr_io_pkg::*;
#(
  parameter int SEED_W = SEED_W_DEF
);
  logic              btn_raw;
  logic [SEED_W-1:0] sw_raw;
  logic              load;
  logic [SEED_W-1:0] seed;
  logic              busy;
  logic [7:0]        press_cnt;

  modport master (
    output btn_raw, sw_raw,
    input  load, seed, busy, press_cnt
  );

  modport slave (
    input  btn_raw, sw_raw,
    output load, seed, busy, press_cnt
  );
endinterface

// File: rtl/seed_load_ctrl_sync2.sv
// Two-flop synchroniser for asynchronous level inputs, any width.
// Latency 2 cycles; no backpressure.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] stage1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1 <= '0;
      q      <= '0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end
endmodule

// File: rtl/seed_load_ctrl.sv
// Debounced push-button to single-cycle LFSR load pulse with a captured switch seed.
// Load fires DB_CYCLES+2 edges after btn is first sampled high; no backpressure.
module seed_load_ctrl
  import lfsr_io_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES = 16'd50000,
  parameter int          SEED_W    = SEED_W_DEF
) (
  input logic             clk,
  input logic             rst_n,
  seed_load_ctrl_if.slave io
);
  localparam int                CNT_W    = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 16'd1);

  logic              btn_s;
  logic [SEED_W-1:0] sw_s;

  sync2 #(.W(1)) u_sync_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (io.btn_raw),
    .q     (btn_s)
  );

  sync2 #(.W(SEED_W)) u_sync_sw (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (io.sw_raw),
    .q     (sw_s)
  );

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              fire;
  logic              load_q;
  logic [SEED_W-1:0] seed_q;
  logic [7:0]        press_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) state_nxt = PRESS_CHK;
      end
      PRESS_CHK: begin
        if (!btn_s) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          fire      = 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) state_nxt = RELEASE_CHK;
      end
      RELEASE_CHK: begin
        if (btn_s) begin
          state_nxt = HELD;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter restarts on any state change so each check window measures a stable level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q      <= 1'b0;
      seed_q      <= '0;
      press_cnt_q <= 8'h00;
    end else begin
      load_q <= fire;
      if (fire) begin
        seed_q      <= sw_s;
        press_cnt_q <= press_cnt_q + 8'h01;
      end
    end
  end

  assign io.load      = load_q;
  assign io.seed      = seed_q;
  assign io.press_cnt = press_cnt_q;
  assign io.busy      = (state != IDLE);
endmodule
